jtgng_upload: RTL and testbench

JTGNG_UPLOAD -- requirements
Module: jtgng_upload

---
 rtl/jtgng_upload_if.sv | 26 ++
 rtl/jtgng_upload.sv | 162 ++++++++++++++++
 tb/tb_jtgng_upload.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/jtgng_upload_if.sv
// Signal bundle between the upload engine, the HPS ioctl port and the SDRAM read port.
// The design side uses 'slave'; the environment (HPS plus SDRAM) uses 'master'.
interface jtgng_upload_if #(
  parameter int AW = 25
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          sdram_req;
  logic [21:0]   sdram_addr;
  logic [31:0]   data_read;
  logic          data_ok;
  logic          up_err;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, data_read, data_ok,
    input  ioctl_din, ioctl_wait, sdram_req, sdram_addr, up_err
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, data_read, data_ok,
    output ioctl_din, ioctl_wait, sdram_req, sdram_addr, up_err
  );
endinterface

// File: rtl/jtgng_upload.sv
// Serves HPS byte reads during an upload session from SDRAM, through a one-word
// (32-bit) buffer, with a timeout that returns 8'hFF and flags up_err.
module jtgng_upload #(
  parameter int TOUT = 255,
  parameter int AW   = 25
) (
  input  logic            clk,
  input  logic            rst,
  jtgng_upload_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

  state_t        state_reg, state_next;
  logic          valid_reg, valid_next;
  logic [AW-3:0] tag_reg, tag_next;
  logic [AW-3:0] pend_tag_reg, pend_tag_next;
  logic [1:0]    lo_reg, lo_next;
  logic [31:0]   word_reg, word_next;
  logic [7:0]    din_reg, din_next;
  logic          wait_reg, wait_next;
  logic          req_reg, req_next;
  logic [21:0]   addr_reg, addr_next;
  logic          err_reg, err_next;
  logic          fail_reg, fail_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          upload_last_reg;

  logic [7:0]    word_byte [4];
  logic          tag_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_byte[gi] = word_reg[8*gi +: 8];
  end

  assign tag_hit = valid_reg && (bus.ioctl_addr[AW-1:2] == tag_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      valid_reg       <= 1'b0;
      tag_reg         <= '0;
      pend_tag_reg    <= '0;
      lo_reg          <= 2'd0;
      word_reg        <= 32'd0;
      din_reg         <= 8'h00;
      wait_reg        <= 1'b0;
      req_reg         <= 1'b0;
      addr_reg        <= 22'd0;
      err_reg         <= 1'b0;
      fail_reg        <= 1'b0;
      cnt_reg         <= 8'd0;
      upload_last_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      valid_reg       <= valid_next;
      tag_reg         <= tag_next;
      pend_tag_reg    <= pend_tag_next;
      lo_reg          <= lo_next;
      word_reg        <= word_next;
      din_reg         <= din_next;
      wait_reg        <= wait_next;
      req_reg         <= req_next;
      addr_reg        <= addr_next;
      err_reg         <= err_next;
      fail_reg        <= fail_next;
      cnt_reg         <= cnt_next;
      upload_last_reg <= bus.ioctl_upload;
    end
  end

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    tag_next      = tag_reg;
    pend_tag_next = pend_tag_reg;
    lo_next       = lo_reg;
    word_next     = word_reg;
    din_next      = din_reg;
    wait_next     = wait_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    err_next      = err_reg;
    fail_next     = fail_reg;
    cnt_next      = cnt_reg;

    if (bus.ioctl_upload && !upload_last_reg)
      err_next = 1'b0;

    if (!bus.ioctl_upload) begin
      // Session closed: forget the buffer and abandon any pending fetch.
      state_next = IDLE;
      valid_next = 1'b0;
      wait_next  = 1'b0;
      req_next   = 1'b0;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ioctl_rd && !wait_reg) begin
            if (tag_hit) begin
              din_next = word_byte[bus.ioctl_addr[1:0]];
            end else begin
              // Word address wraps into the 22-bit SDRAM space; always even.
              addr_next     = {bus.ioctl_addr[22:2], 1'b0};
              pend_tag_next = bus.ioctl_addr[AW-1:2];
              lo_next       = bus.ioctl_addr[1:0];
              req_next      = 1'b1;
              wait_next     = 1'b1;
              cnt_next      = 8'd0;
              fail_next     = 1'b0;
              state_next    = FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.data_ok) begin
            word_next  = bus.data_read;
            tag_next   = pend_tag_reg;
            valid_next = 1'b1;
            req_next   = 1'b0;
            state_next = DELIVER;
          end else if (cnt_reg == TOUT_LAST) begin
            din_next   = 8'hFF;
            err_next   = 1'b1;
            valid_next = 1'b0;
            req_next   = 1'b0;
            fail_next  = 1'b1;
            state_next = DELIVER;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        DELIVER: begin
          // A timed-out fetch keeps the 8'hFF already placed on ioctl_din.
          if (!fail_reg)
            din_next = word_byte[lo_reg];
          wait_next  = 1'b0;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          req_next   = 1'b0;
          wait_next  = 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_din  = din_reg;
  assign bus.ioctl_wait = wait_reg;
  assign bus.sdram_req  = req_reg;
  assign bus.sdram_addr = addr_reg;
  assign bus.up_err     = err_reg;

endmodule

// File: tb/tb_jtgng_upload.sv
// Directed bench for jtgng_upload (TOUT=8): hits/misses, timeout, abort,
// address wrap, asynchronous reset and ignored strobes.
module tb_jtgng_upload;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  jtgng_upload_if #(.AW(25)) bus ();

  jtgng_upload #(.TOUT(8), .AW(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
  endtask

  task automatic pulse_ok(input logic [31:0] d);
    bus.data_read = d;
    bus.data_ok   = 1'b1;
    tick();
    bus.data_ok   = 1'b0;
  endtask

  initial begin
    logic [7:0] hit_exp [3];
    hit_exp[0] = 8'hBB;
    hit_exp[1] = 8'hCC;
    hit_exp[2] = 8'hDD;
    n_vec = 0;
    n_bad = 0;
    rst              = 1'b1;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.data_read    = 32'd0;
    bus.data_ok      = 1'b0;
    tick();
    tick();
    check("rst_din",   {24'd0, bus.ioctl_din}, 32'h00);
    check("rst_wait",  {31'd0, bus.ioctl_wait}, 32'd0);
    check("rst_req",   {31'd0, bus.sdram_req}, 32'd0);
    check("rst_addr",  {10'd0, bus.sdram_addr}, 32'd0);
    check("rst_err",   {31'd0, bus.up_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Strobe with no upload session is ignored
    strobe(25'h000100);
    check("noup_req",  {31'd0, bus.sdram_req}, 32'd0);
    check("noup_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    bus.ioctl_upload = 1'b1;
    tick();

    // Miss at 0x100, data after 5 cycles
    strobe(25'h000100);
    check("miss_req",  {31'd0, bus.sdram_req}, 32'd1);
    check("miss_wait", {31'd0, bus.ioctl_wait}, 32'd1);
    check("miss_addr", {10'd0, bus.sdram_addr}, 32'h80);
    tick();
    strobe(25'h000300);  // strobe while wait is high: ignored
    check("rdwait_addr", {10'd0, bus.sdram_addr}, 32'h80);
    tick();
    tick();
    check("fetch_wait", {31'd0, bus.ioctl_wait}, 32'd1);
    check("fetch_req",  {31'd0, bus.sdram_req}, 32'd1);
    pulse_ok(32'hDDCCBBAA);
    check("ok_req",    {31'd0, bus.sdram_req}, 32'd0);
    check("ok_wait",   {31'd0, bus.ioctl_wait}, 32'd1);
    tick();
    check("dlv_wait",  {31'd0, bus.ioctl_wait}, 32'd0);
    check("dlv_din",   {24'd0, bus.ioctl_din}, 32'hAA);

    // Hits on the same word
    for (int i = 0; i < 3; i++) begin
      strobe(25'h000101 + 25'(i));
      check($sformatf("hit%0d_din", i),  {24'd0, bus.ioctl_din}, {24'd0, hit_exp[i]});
      check($sformatf("hit%0d_wait", i), {31'd0, bus.ioctl_wait}, 32'd0);
      check($sformatf("hit%0d_req", i),  {31'd0, bus.sdram_req}, 32'd0);
    end

    // Adjacent word misses
    strobe(25'h000104);
    check("adj_req",  {31'd0, bus.sdram_req}, 32'd1);
    check("adj_addr", {10'd0, bus.sdram_addr}, 32'h82);
    pulse_ok(32'h44332211);
    tick();
    check("adj_din",  {24'd0, bus.ioctl_din}, 32'h11);

    // Timeout at 0x20: request held 8 cycles then dropped
    strobe(25'h000020);
    check("to_addr", {10'd0, bus.sdram_addr}, 32'h10);
    for (int i = 0; i < 7; i++) tick();
    check("to_req_held", {31'd0, bus.sdram_req}, 32'd1);
    tick();
    check("to_req_drop", {31'd0, bus.sdram_req}, 32'd0);
    check("to_err",      {31'd0, bus.up_err}, 32'd1);
    tick();
    check("to_din",      {24'd0, bus.ioctl_din}, 32'hFF);
    check("to_wait",     {31'd0, bus.ioctl_wait}, 32'd0);

    // Old 0x104 word was invalidated by the timeout: miss, then abort
    strobe(25'h000105);
    check("inv_req", {31'd0, bus.sdram_req}, 32'd1);
    tick();
    bus.ioctl_upload = 1'b0;
    tick();
    check("abort_req",  {31'd0, bus.sdram_req}, 32'd0);
    check("abort_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    check("abort_din",  {24'd0, bus.ioctl_din}, 32'hFF);
    pulse_ok(32'h99999999);
    check("stray_req",  {31'd0, bus.sdram_req}, 32'd0);
    check("stray_din",  {24'd0, bus.ioctl_din}, 32'hFF);
    check("err_held",   {31'd0, bus.up_err}, 32'd1);
    bus.ioctl_upload = 1'b1;
    tick();
    check("err_clear",  {31'd0, bus.up_err}, 32'd0);

    // Buffer invalid after abort: 0x105 misses again
    strobe(25'h000105);
    check("post_abort_req", {31'd0, bus.sdram_req}, 32'd1);
    pulse_ok(32'h44332211);
    tick();
    check("post_abort_din", {24'd0, bus.ioctl_din}, 32'h22);

    // Address wrap: bit 23 ignored in the SDRAM address
    strobe(25'h800100);
    check("wrap_req",  {31'd0, bus.sdram_req}, 32'd1);
    check("wrap_addr", {10'd0, bus.sdram_addr}, 32'h80);

    // Asynchronous reset mid-fetch, between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",  {31'd0, bus.sdram_req}, 32'd0);
    check("arst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    check("arst_din",  {24'd0, bus.ioctl_din}, 32'h00);
    check("arst_addr", {10'd0, bus.sdram_addr}, 32'd0);
    tick();
    rst = 1'b0;
    pulse_ok(32'h12345678);
    check("arst_stray_req",  {31'd0, bus.sdram_req}, 32'd0);
    check("arst_stray_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    check("arst_stray_din",  {24'd0, bus.ioctl_din}, 32'h00);
    strobe(25'h000101);
    check("arst_miss_req", {31'd0, bus.sdram_req}, 32'd1);
    check("arst_miss_addr", {10'd0, bus.sdram_addr}, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
